// File: rtl/aes_128_sched.sv
// Round-robin scheduler sharing one pipelined AES-128 core between two requesters.
// Blocks are tagged with their requester ID; credits keep each result FIFO from overflowing.
module aes_128_sched #(
    parameter int unsigned CORE_LAT   = 20,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_state,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_state,
    input  logic [127:0] req1_key,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [127:0] rsp0_data,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp1_data,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         busy
);

    localparam int unsigned TAG_N = CORE_LAT + 2;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned DW    = 128;

    logic             live;
    logic             prefer1;
    logic [TAG_N-1:0] tag_v;
    logic [TAG_N-1:0] tag_id;
    logic [CW-1:0]    cred   [2];
    logic [CW-1:0]    cnt    [2];
    logic [PW-1:0]    wptr   [2];
    logic [PW-1:0]    rptr   [2];
    logic [DW-1:0]    mem    [2][FIFO_DEPTH];

    logic [1:0] valid_c;
    logic [1:0] rsp_rdy_c;
    logic [1:0] elig_c;
    logic [1:0] grant_c;
    logic [1:0] nempty_c;
    logic [1:0] pop_c;
    logic [1:0] wr_c;
    logic       issue_c;

    assign valid_c   = {req1_valid, req0_valid};
    assign rsp_rdy_c = {rsp1_ready, rsp0_ready};

    // Eligibility and round-robin grant; prefer1 names the requester that wins a tie.
    always_comb begin
        elig_c  = '0;
        grant_c = '0;
        for (int n = 0; n < 2; n++) begin
            elig_c[n] = live && valid_c[n] && (cred[n] < CW'(FIFO_DEPTH));
        end
        if (elig_c[0] && (!elig_c[1] || !prefer1)) begin
            grant_c[0] = 1'b1;
        end else if (elig_c[1]) begin
            grant_c[1] = 1'b1;
        end
    end

    assign issue_c    = |grant_c;
    assign req0_ready = grant_c[0];
    assign req1_ready = grant_c[1];

    // FIFO handshakes; the last tag stage steers core_out to its owner.
    always_comb begin
        nempty_c = '0;
        pop_c    = '0;
        wr_c     = '0;
        for (int n = 0; n < 2; n++) begin
            nempty_c[n] = (cnt[n] != '0);
            pop_c[n]    = nempty_c[n] && rsp_rdy_c[n];
            wr_c[n]     = tag_v[TAG_N-1] && (tag_id[TAG_N-1] == 1'(n));
        end
    end

    assign rsp0_valid = nempty_c[0];
    assign rsp1_valid = nempty_c[1];
    assign rsp0_data  = mem[0][rptr[0]];
    assign rsp1_data  = mem[1][rptr[1]];
    assign busy       = (|tag_v) || (|nempty_c);

    // Control state: arbitration pointer, core operands, tag pipe, credits, FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live       <= 1'b0;
            prefer1    <= 1'b0;
            core_state <= '0;
            core_key   <= '0;
            tag_v      <= '0;
            tag_id     <= '0;
            for (int n = 0; n < 2; n++) begin
                cred[n] <= '0;
                cnt[n]  <= '0;
                wptr[n] <= '0;
                rptr[n] <= '0;
            end
        end else begin
            live <= 1'b1;
            if (issue_c) begin
                prefer1    <= grant_c[0];
                core_state <= grant_c[1] ? req1_state : req0_state;
                core_key   <= grant_c[1] ? req1_key   : req0_key;
            end
            tag_v  <= {tag_v[TAG_N-2:0], issue_c};
            tag_id <= {tag_id[TAG_N-2:0], grant_c[1]};
            for (int n = 0; n < 2; n++) begin
                cred[n] <= cred[n] + CW'(grant_c[n]) - CW'(pop_c[n]);
                cnt[n]  <= cnt[n] + CW'(wr_c[n]) - CW'(pop_c[n]);
                wptr[n] <= wptr[n] + PW'(wr_c[n]);
                rptr[n] <= rptr[n] + PW'(pop_c[n]);
            end
        end
    end

    // Result storage; contents need no reset because occupancy is tracked by cnt.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (wr_c[n]) begin
                mem[n][wptr[n]] <= core_out;
            end
        end
    end

endmodule
